rc4_xor_stream: RTL and testbench

Consumer end of the RC4 keystream interface. It accepts keystream bytes from the RC4 generator, buffers them in a small FIFO, and XORs each byte with one incoming data byte. The resulting ciphertext (or plaintext) byte leaves on a valid/ready stream. The block sits between the RC4 core and the data path, and the same hardware performs both encryption and decryption.

---
 rtl/rc4_xor_stream.sv | 193 +++++++++++++++++++
 tb/tb_rc4_xor_stream.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_xor_stream.sv
// rc4_xor_stream
// ----------------------------------------------------------------------------
// This block is the consumer end of an RC4 keystream. It buffers keystream
// bytes in a small FIFO and XORs each byte with one incoming data byte. The
// result leaves on a valid/ready stream. Encryption and decryption use the
// same operation.
//
// Optional build macro: RC4_DROP_EN
//   When this macro is defined, a DROP state runs after start and before RUN.
//   DROP discards the first DROP_N keystream bytes (RC4-drop[n]).
//   When it is undefined, start goes directly to RUN and DROP_N is ignored.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, msg_len      start a message of msg_len bytes (sampled only in IDLE)
//   ks_valid/ks_ready   keystream input handshake, byte on ks_data
//   din_valid/din_ready data input handshake, byte on din
//   dout_valid/dout_ready  result output handshake, dout = din ^ keystream
//   busy                high whenever the block is not idle
//   done                one-cycle pulse at the end of a message
//   byte_cnt            data bytes accepted in the current message
module rc4_xor_stream #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8,
  parameter int DROP_N     = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  output logic             ks_ready,
  input  logic             din_valid,
  input  logic [7:0]       din,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [7:0]       dout,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef RC4_DROP_EN
  localparam logic [2:0] ST_DROP  = 3'd4;
  localparam int DROP_W = (DROP_N < 1) ? 1 : $clog2(DROP_N + 1);
`endif

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [LEN_W-1:0] len;

  logic fifo_full;
  logic fifo_empty;
  logic ks_push;
  logic din_pop;
  logic out_fire;
  logic last_byte;

  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  always_comb begin
    ks_ready = 1'b0;
    case (state)
      ST_RUN:  ks_ready = !fifo_full;
`ifdef RC4_DROP_EN
      ST_DROP: ks_ready = 1'b1;
`endif
      default: ks_ready = 1'b0;
    endcase
  end

  // A new byte is taken only when the output register is free or is emptied
  // this cycle, so the pipeline can run at one byte per cycle.
  assign din_ready = (state == ST_RUN) && !fifo_empty &&
                     (!dout_valid || dout_ready) && (byte_cnt < len);

  // Bytes consumed in DROP are discarded. They never enter the FIFO.
  assign ks_push   = ks_valid && ks_ready && (state == ST_RUN);
  assign din_pop   = din_valid && din_ready;
  assign out_fire  = dout_valid && dout_ready;
  assign last_byte = din_pop && ((byte_cnt + LEN_W'(1)) == len);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

`ifdef RC4_DROP_EN
  logic [DROP_W-1:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (state == ST_IDLE) begin
      drop_cnt <= '0;
    end else if (state == ST_DROP && ks_valid) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (msg_len == '0) begin
            state_next = ST_DONE;
          end else begin
`ifdef RC4_DROP_EN
            state_next = (DROP_N < 1) ? ST_RUN : ST_DROP;
`else
            state_next = ST_RUN;
`endif
          end
        end
      end
`ifdef RC4_DROP_EN
      ST_DROP: begin
        if (ks_valid && (drop_cnt == DROP_W'(DROP_N - 1))) state_next = ST_RUN;
      end
`endif
      ST_RUN:   if (last_byte) state_next = ST_DRAIN;
      ST_DRAIN: if (out_fire) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The keystream storage has no reset. Only the pointers and the count need
  // to be reset.
  always_ff @(posedge clk) begin
    if (ks_push) fifo_mem[wr_ptr] <= ks_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      len        <= '0;
      byte_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state <= state_next;

      // Keystream left over at the end of a message is flushed, so the next
      // message starts only with fresh bytes.
      if (state == ST_DONE) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (ks_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (din_pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({ks_push, din_pop})
          2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
          2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
      end

      if (state == ST_IDLE && start) begin
        len      <= msg_len;
        byte_cnt <= '0;
      end else if (din_pop) begin
        byte_cnt <= byte_cnt + LEN_W'(1);
      end

      if (din_pop) begin
        dout       <= din ^ fifo_mem[rd_ptr];
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// tb_rc4_xor_stream
// This bench drives rc4_xor_stream with directed and random messages.
// A reference model checks each result byte. Result byte i of a message must
// equal data byte i XOR keystream byte i, where keystream byte i is counted
// after any dropped bytes.
// If RC4_DROP_EN is defined, also define it for this bench.
module tb_rc4_xor_stream;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 8;
  localparam int DROP_N     = 4;
`ifdef RC4_DROP_EN
  localparam int MODEL_DROP = DROP_N;
`else
  localparam int MODEL_DROP = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic             ks_valid = 1'b0;
  logic [7:0]       ks_data = 8'h00;
  logic             ks_ready;
  logic             din_valid = 1'b0;
  logic [7:0]       din = 8'h00;
  logic             din_ready;
  logic             dout_valid;
  logic [7:0]       dout;
  logic             dout_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] byte_cnt;

  always #5 clk = ~clk;

  rc4_xor_stream #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .LEN_W     (LEN_W),
    .DROP_N    (DROP_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .msg_len   (msg_len),
    .ks_valid  (ks_valid),
    .ks_data   (ks_data),
    .ks_ready  (ks_ready),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .dout_valid(dout_valid),
    .dout      (dout),
    .dout_ready(dout_ready),
    .busy      (busy),
    .done      (done),
    .byte_cnt  (byte_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Stimulus sources and the model of the current message
  logic [7:0] ks_src[$];
  logic [7:0] din_src[$];
  logic [7:0] ks_got[$];
  logic [7:0] din_got[$];
  logic [7:0] out_log[$];
  int exp_len, n_out, dropped, first_out_cyc, last_out_cyc, done_cyc;
  bit saw_done;
  logic [LEN_W-1:0] done_byte_cnt;

  // These are DUT signals sampled just before the active edge of the last step
  logic s_ks_ready, s_din_ready, s_dout_valid, s_done, s_busy;
  logic [7:0] s_dout;

  // One clock cycle: drive the inputs on the falling edge, sample at +1,
  // then update the model from the handshakes that happen on the next
  // rising edge.
  task automatic step(input bit ksv, input bit dv, input bit dr);
    int occ;
    logic [7:0] exp_b;
    @(negedge clk);
    ks_valid = ksv && (ks_src.size() > 0);
    ks_data  = ks_valid ? ks_src[0] : 8'h00;
    din_valid = dv && (din_src.size() > 0);
    din      = din_valid ? din_src[0] : 8'h00;
    dout_ready = dr;
    #1;
    s_ks_ready = ks_ready; s_din_ready = din_ready; s_dout_valid = dout_valid;
    s_dout = dout; s_done = done; s_busy = busy;
    occ = ks_got.size() - din_got.size();
    if (dout_valid && dout_ready) begin
      vectors++;
      if (n_out >= exp_len || n_out >= din_got.size()) begin
        miscompares++;
        $display("FAIL out_extra: result byte %0d got %02h, expected no byte (len %0d)", n_out, dout, exp_len);
      end else begin
        exp_b = din_got[n_out] ^ ks_got[n_out];
        if (dout !== exp_b) begin
          miscompares++;
          $display("FAIL out_byte[%0d]: got %02h expected %02h", n_out, dout, exp_b);
        end
        if (n_out == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_log.push_back(dout);
        n_out++;
      end
    end
    if (din_valid && din_ready) begin
      vectors++;
      if (occ <= 0 || din_got.size() >= exp_len) begin
        miscompares++;
        $display("FAIL din_accept: byte accepted with keystream fill %0d, %0d of %0d taken", occ, din_got.size(), exp_len);
      end
      din_got.push_back(din);
      void'(din_src.pop_front());
    end
    if (ks_valid && ks_ready) begin
      if (dropped < MODEL_DROP) begin
        dropped++;
      end else begin
        vectors++;
        if (occ >= FIFO_DEPTH) begin
          miscompares++;
          $display("FAIL ks_overflow: keystream accepted at fill %0d, expected at most %0d", occ, FIFO_DEPTH - 1);
        end
        ks_got.push_back(ks_data);
      end
      void'(ks_src.pop_front());
    end
    if (done) begin
      saw_done = 1'b1;
      done_cyc = cyc;
      done_byte_cnt = byte_cnt;
    end
    cyc++;
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    start = 1'b1; msg_len = LEN_W'(len);
    ks_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    exp_len = len; n_out = 0; dropped = 0; saw_done = 1'b0;
    ks_got.delete(); din_got.delete(); out_log.delete();
    ks_src.delete(); din_src.delete();
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_busy: busy=%b expected 1", busy);
    end
    cyc++;
  endtask

  task automatic fill_random(input int len, input int extra_ks);
    for (int i = 0; i < MODEL_DROP + len + extra_ks; i++) ks_src.push_back(8'($urandom));
    for (int i = 0; i < len; i++) din_src.push_back(8'($urandom));
  endtask

  // Runs until done is seen, then checks the end-of-message state
  task automatic run_loop(input int max_cyc, input int ks_pct, input int din_pct, input int rdy_pct);
    int c = 0;
    while (!saw_done && c < max_cyc) begin
      step($urandom_range(0, 99) < ks_pct, $urandom_range(0, 99) < din_pct,
           $urandom_range(0, 99) < rdy_pct);
      c++;
    end
    vectors++;
    if (!saw_done) begin
      miscompares++;
      $display("FAIL msg_timeout: no done after %0d cycles, %0d of %0d bytes out", max_cyc, n_out, exp_len);
    end else begin
      vectors++;
      if (n_out != exp_len || done_byte_cnt !== LEN_W'(exp_len)) begin
        miscompares++;
        $display("FAIL msg_count: outputs=%0d byte_cnt=%0d expected %0d", n_out, done_byte_cnt, exp_len);
      end
      step(1'b0, 1'b0, 1'b1);
      vectors++;
      if (s_done !== 1'b0 || s_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse: after done got done=%b busy=%b expected 0 0", s_done, s_busy);
      end
    end
    $display("msg len=%0d outputs=%0d cycles=%0d", exp_len, n_out, c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({ks_ready, din_ready, dout_valid, busy, done} !== 5'b0 || dout !== 8'h00 || byte_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ks_rdy=%b din_rdy=%b dv=%b busy=%b done=%b dout=%02h cnt=%0d expected all 0",
               ks_ready, din_ready, dout_valid, busy, done, dout, byte_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_out [3];
    exp_out[0] = 8'hBB; exp_out[1] = 8'hF3; exp_out[2] = 8'h16;
    do_start(3);
    for (int i = 0; i < MODEL_DROP; i++) ks_src.push_back(8'($urandom));
    ks_src.push_back(8'hEB); ks_src.push_back(8'h9F); ks_src.push_back(8'h77);
    din_src.push_back(8'h50); din_src.push_back(8'h6C); din_src.push_back(8'h61);
    run_loop(60, 100, 100, 100);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= out_log.size() || out_log[i] !== exp_out[i]) begin
        miscompares++;
        $display("FAIL basic_vec[%0d]: got %02h expected %02h", i,
                 (i < out_log.size()) ? out_log[i] : 8'hxx, exp_out[i]);
      end
    end
    vectors++;
    if (last_out_cyc - first_out_cyc != 2 || done_cyc != last_out_cyc + 1) begin
      miscompares++;
      $display("FAIL basic_timing: outputs span %0d cycles, done %0d after last, expected 2 and 1",
               last_out_cyc - first_out_cyc, done_cyc - last_out_cyc);
    end
  endtask

  task automatic test_backpressure();
    int w = 0;
    do_start(3);
    for (int i = 0; i < MODEL_DROP; i++) ks_src.push_back(8'($urandom));
    ks_src.push_back(8'hEB); ks_src.push_back(8'h9F); ks_src.push_back(8'h77);
    din_src.push_back(8'h50); din_src.push_back(8'h6C); din_src.push_back(8'h61);
    s_dout_valid = 1'b0;
    while (!s_dout_valid && w < 30) begin
      step(1'b1, 1'b1, 1'b0);
      w++;
    end
    vectors++;
    if (s_dout_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_first: dout_valid=%b expected 1 within 30 cycles", s_dout_valid);
    end else begin
      for (int i = 1; i < 5; i++) begin
        step(1'b1, 1'b1, 1'b0);
        vectors++;
        if (s_dout_valid !== 1'b1 || s_dout !== 8'hBB || s_din_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_hold[%0d]: dv=%b dout=%02h din_rdy=%b expected 1 bb 0",
                   i, s_dout_valid, s_dout, s_din_ready);
        end
      end
    end
    run_loop(100, 100, 100, 100);
  endtask

  task automatic test_starvation();
    int w = 0;
    do_start(4);
    fill_random(4, 4);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1);
      vectors++;
      if (s_din_ready !== 1'b0 || s_dout_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL starve[%0d]: din_rdy=%b dv=%b expected 0 0", i, s_din_ready, s_dout_valid);
      end
    end
    while (ks_got.size() < FIFO_DEPTH && w < 30) begin
      step(1'b1, 1'b0, 1'b1);
      w++;
    end
    step(1'b1, 1'b0, 1'b1);
    vectors++;
    if (s_ks_ready !== 1'b0 || ks_got.size() != FIFO_DEPTH) begin
      miscompares++;
      $display("FAIL fifo_full: ks_ready=%b stored=%0d expected 0 %0d", s_ks_ready, ks_got.size(), FIFO_DEPTH);
    end
    run_loop(200, 100, 100, 100);
  endtask

  task automatic test_zero_len();
    do_start(0);
    ks_src.push_back(8'h11); din_src.push_back(8'h22);
    ks_valid = 1'b1; din_valid = 1'b1; ks_data = 8'h11; din = 8'h22;
    #1;
    vectors++;
    if (done !== 1'b1 || ks_ready !== 1'b0 || din_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: done=%b ks_rdy=%b din_rdy=%b expected 1 0 0", done, ks_ready, din_ready);
    end
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || ks_src.size() != 1 || din_src.size() != 1) begin
      miscompares++;
      $display("FAIL zero_after: done=%b busy=%b ks_left=%0d din_left=%0d expected 0 0 1 1",
               s_done, s_busy, ks_src.size(), din_src.size());
    end
  endtask

  task automatic test_flush_restart();
    int w = 0;
    do_start(2);
    fill_random(2, 2);
    while (ks_got.size() < FIFO_DEPTH && w < 30) begin
      step(1'b1, 1'b0, 1'b1);
      w++;
    end
    run_loop(100, 0, 100, 100);
    // The second message must use only new keystream and must ignore a
    // start pulse that arrives mid-message.
    do_start(2);
    fill_random(2, 0);
    start = 1'b1; msg_len = LEN_W'(7);
    step(1'b1, 1'b1, 1'b1);
    start = 1'b0; msg_len = '0;
    run_loop(100, 100, 100, 100);
  endtask

  task automatic test_random();
    for (int m = 0; m < 8; m++) begin
      int len = $urandom_range(1, 12);
      do_start(len);
      fill_random(len, $urandom_range(0, 5));
      run_loop(3000, $urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100));
    end
  endtask

  task automatic test_async_reset();
    int w = 0;
    do_start(3);
    fill_random(3, 0);
    while (n_out < 1 && w < 40) begin
      step(1'b1, 1'b1, 1'b1);
      w++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ks_ready, din_ready, dout_valid, busy, done} !== 5'b0 || dout !== 8'h00 || byte_cnt !== '0) begin
      miscompares++;
      $display("FAIL async_reset: ks_rdy=%b din_rdy=%b dv=%b busy=%b done=%b dout=%02h cnt=%0d expected all 0",
               ks_ready, din_ready, dout_valid, busy, done, dout, byte_cnt);
    end
    @(negedge clk);
    ks_valid = 1'b0; din_valid = 1'b0;
    rst_n = 1'b1;
    do_start(3);
    fill_random(3, 2);
    run_loop(200, 100, 100, 100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_zero_len();
    test_flush_restart();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
